qam_mapper_mm: RTL and testbench

// Multi-mode constellation mapper for the 802.16 OFDM TX chain: BPSK/QPSK/16-QAM/64-QAM selected per burst.

---
 rtl/qam_mapper_mm_if.sv | 16 +
 rtl/qam_mapper_mm.sv | 215 +++++++++++++++++++++
 tb/tb_qam_mapper_mm.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_mapper_mm_if.sv
// Wishbone-style point-to-point link used on both sides of the mapper.
// The master drives the cycle/strobe/write/data; the slave answers with ack.
`timescale 1ns/1ps

interface qam_mapper_mm_if #(
    parameter int W = 6
);
    logic         cyc;
    logic         stb;
    logic         we;
    logic         ack;
    logic [W-1:0] dat;

    modport master (output cyc, stb, we, dat, input  ack);
    modport slave  (input  cyc, stb, we, dat, output ack);
endinterface

// File: rtl/qam_mapper_mm.sv
// Multi-mode constellation mapper (BPSK / QPSK / 16-QAM / 64-QAM).
// One symbol's bits per upstream write, one {Im,Re} sample per downstream
// beat. A one-entry input stage (s1) feeds a small output FIFO; a credit
// rule on ACK guarantees the FIFO can never overflow under back-pressure.
`timescale 1ns/1ps

module qam_mapper_mm #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    qam_mapper_mm_if.slave     up,
    qam_mapper_mm_if.master    dn,
    output logic [CNT_W-1:0]   sym_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Constellation levels in Q2.(DW-2). Each mode's unit step is rounded
    // once; the odd multiples (3, 5, 7) are exact integer multiples of that
    // rounded step so the grid stays perfectly uniform.
    localparam int  U_ONE   = 1 << (DW - 2);
    localparam real SCALE   = $itor(U_ONE);
    localparam int  U_QPSK  = $rtoi(SCALE / $sqrt(2.0)  + 0.5);
    localparam int  U_QAM16 = $rtoi(SCALE / $sqrt(10.0) + 0.5);
    localparam int  U_QAM64 = $rtoi(SCALE / $sqrt(42.0) + 0.5);

    localparam logic [DW-1:0] LV_BPSK  = DW'(U_ONE);
    localparam logic [DW-1:0] LV_QPSK  = DW'(U_QPSK);
    localparam logic [DW-1:0] LV16_1   = DW'(U_QAM16);
    localparam logic [DW-1:0] LV16_3   = DW'(3 * U_QAM16);
    localparam logic [DW-1:0] LV64_1   = DW'(U_QAM64);
    localparam logic [DW-1:0] LV64_3   = DW'(3 * U_QAM64);
    localparam logic [DW-1:0] LV64_5   = DW'(5 * U_QAM64);
    localparam logic [DW-1:0] LV64_7   = DW'(7 * U_QAM64);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef enum logic [1:0] {MODE_BPSK, MODE_QPSK, MODE_QAM16, MODE_QAM64} mode_e;

    state_e            state;
    mode_e             mode_q;
    logic              cyc_q;

    logic              ena;
    logic              ack;
    logic [AW:0]       in_flight;

    logic              s1_valid;
    logic [5:0]        s1_bits;

    logic              re_neg;
    logic              im_neg;
    logic [DW-1:0]     re_mag;
    logic [DW-1:0]     im_mag;
    logic [2*DW-1:0]   sample;

    logic [2*DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic              push;
    logic              pop;
    logic              stb;

    // 64-QAM Gray-coded magnitude: 00->1, 01->3, 11->5, 10->7.
    function automatic logic [DW-1:0] lvl64(input logic [1:0] g);
        case (g)
            2'b00:   return LV64_1;
            2'b01:   return LV64_3;
            2'b11:   return LV64_5;
            default: return LV64_7;
        endcase
    endfunction

    // Credit rule: a symbol is only accepted if the FIFO still has room for
    // everything already in flight, so s1 can always drain on the next edge.
    assign in_flight = fifo_cnt + {{AW{1'b0}}, s1_valid};
    assign ena       = up.cyc & up.stb & up.we & (state == RUN);
    assign ack       = ena & (in_flight < (AW+1)'(FIFO_DEPTH));
    assign up.ack    = ack;

    // Burst control: latches the mode at burst start, counts accepted symbols
    // and holds the downstream cycle open until the pipeline has drained.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cyc_q   <= 1'b0;
            mode_q  <= MODE_BPSK;
            sym_cnt <= '0;
        end else begin
            if (ack) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (up.cyc) begin
                        state   <= RUN;
                        cyc_q   <= 1'b1;
                        mode_q  <= mode_e'(mode);
                        sym_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!up.cyc) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && (fifo_cnt == '0)) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    // Input stage: captures raw bits of each accepted symbol for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bits  <= '0;
        end else begin
            s1_valid <= ack;
            if (ack) begin
                s1_bits <= up.dat;
            end
        end
    end

    // Map the staged bits to a signed {Im,Re} sample for the burst's mode.
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value held and no latch is inferred.
    always_comb begin
        re_neg = 1'b0;
        im_neg = 1'b0;
        re_mag = '0;
        im_mag = '0;
        unique case (mode_q)
            MODE_BPSK: begin
                re_neg = s1_bits[0];
                re_mag = LV_BPSK;
            end
            MODE_QPSK: begin
                re_neg = s1_bits[1];
                im_neg = s1_bits[0];
                re_mag = LV_QPSK;
                im_mag = LV_QPSK;
            end
            MODE_QAM16: begin
                re_neg = s1_bits[3];
                im_neg = s1_bits[1];
                re_mag = s1_bits[2] ? LV16_3 : LV16_1;
                im_mag = s1_bits[0] ? LV16_3 : LV16_1;
            end
            MODE_QAM64: begin
                re_neg = s1_bits[5];
                im_neg = s1_bits[2];
                re_mag = lvl64(s1_bits[4:3]);
                im_mag = lvl64(s1_bits[1:0]);
            end
        endcase
        sample = {(im_neg ? ('0 - im_mag) : im_mag),
                  (re_neg ? ('0 - re_mag) : re_mag)};
    end

    assign push = s1_valid;
    assign stb  = (fifo_cnt != '0);
    assign pop  = stb & dn.ack;

    // FIFO pointers and fill count; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array is deliberately not reset; only the pointers
    // and count are, and the output is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    assign dn.stb = stb;
    assign dn.we  = stb;
    assign dn.cyc = cyc_q;
    assign dn.dat = stb ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_qam_mapper_mm.sv
// Directed bench for qam_mapper_mm with a scoreboard of expected samples.
`timescale 1ns/1ps

module tb_qam_mapper_mm;

    localparam logic [1:0] M_BPSK  = 2'b00;
    localparam logic [1:0] M_QPSK  = 2'b01;
    localparam logic [1:0] M_QAM16 = 2'b10;
    localparam logic [1:0] M_QAM64 = 2'b11;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  sym_cnt;

    qam_mapper_mm_if #(.W(6))  up_if ();
    qam_mapper_mm_if #(.W(32)) dn_if ();

    qam_mapper_mm #(.DW(16), .FIFO_DEPTH(2), .CNT_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .up      (up_if),
        .dn      (dn_if),
        .sym_cnt (sym_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [1:0]  burst_mode;
    logic [1:0]  cnt_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sgn(input logic s, input logic [15:0] v);
        return s ? (16'h0000 - v) : v;
    endfunction

    function automatic logic [15:0] lv64(input logic [1:0] g);
        case (g)
            2'b00:   return 16'h09E0;
            2'b01:   return 16'h1DA0;
            2'b11:   return 16'h3160;
            default: return 16'h4520;
        endcase
    endfunction

    // Reference mapping built from the constellation tables, returns {Im,Re}.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [5:0] d);
        logic [15:0] re;
        logic [15:0] im;
        case (m)
            M_BPSK: begin
                re = sgn(d[0], 16'h4000);
                im = 16'h0000;
            end
            M_QPSK: begin
                re = sgn(d[1], 16'h2D41);
                im = sgn(d[0], 16'h2D41);
            end
            M_QAM16: begin
                re = sgn(d[3], d[2] ? 16'h3CB7 : 16'h143D);
                im = sgn(d[1], d[0] ? 16'h3CB7 : 16'h143D);
            end
            default: begin
                re = sgn(d[5], lv64(d[4:3]));
                im = sgn(d[2], lv64(d[1:0]));
            end
        endcase
        return {im, re};
    endfunction

    // Output monitor: every downstream beat pops and compares one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("we_follows_stb", dn_if.we, dn_if.stb);
            if (dn_if.stb && dn_if.ack) begin
                check("sb_has_entry", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("dat_o", dn_if.dat, exp_w);
                end
            end
        end
    end

    task automatic start_burst(input logic [1:0] m);
        mode       = m;
        burst_mode = m;
        cnt_model  = 2'd0;
        up_if.cyc  = 1'b1;
    endtask

    // Present one symbol and hold it until accepted (bounded), then step past the edge.
    task automatic do_write(input logic [5:0] d);
        int n;
        n = 0;
        up_if.dat = d;
        up_if.stb = 1'b1;
        up_if.we  = 1'b1;
        @(negedge clk);
        while (!up_if.ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_within_budget", up_if.ack, 1'b1);
        if (up_if.ack) begin
            exp_q.push_back(model(burst_mode, d));
            cnt_model++;
        end
        @(posedge clk);
        #1;
        check("sym_cnt", sym_cnt, cnt_model);
    endtask

    // Stop writing, let everything drain, close the cycle and wait for CYC_O low.
    task automatic end_burst();
        int n;
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        up_if.cyc = 1'b0;
        n = 0;
        while (dn_if.cyc && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cyc_o_released", dn_if.cyc, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        mode       = M_BPSK;
        burst_mode = M_BPSK;
        cnt_model  = 2'd0;
        up_if.cyc  = 1'b0;
        up_if.stb  = 1'b0;
        up_if.we   = 1'b0;
        up_if.dat  = '0;
        dn_if.ack  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stb", dn_if.stb, 1'b0);
        check("rst_cyc", dn_if.cyc, 1'b0);
        check("rst_dat", dn_if.dat, 32'h0);
        check("rst_cnt", sym_cnt, 2'd0);
        check("rst_ack", up_if.ack, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // QPSK burst, no back-pressure; latency and counter wrap
        dn_if.ack = 1'b1;
        start_burst(M_QPSK);
        do_write(6'b000011);
        check("t1_stb_one_after_ack", dn_if.stb, 1'b0);
        do_write(6'b000010);
        check("t1_stb_two_after_ack", dn_if.stb, 1'b1);
        check("t1_first_sample", dn_if.dat, 32'hD2BFD2BF);
        do_write(6'b000001);
        check("t1_cnt_three", sym_cnt, 2'd3);
        do_write(6'b000000);
        check("t1_cnt_wrap", sym_cnt, 2'd0);
        end_burst();

        // 64-QAM and 16-QAM point checks
        start_burst(M_QAM64);
        do_write(6'b010110);
        do_write(6'b101001);
        do_write(6'b011100);
        end_burst();
        start_burst(M_QAM16);
        do_write(6'b001101);
        do_write(6'b000010);
        end_burst();

        // Back-pressure: two in flight stops ACK_O, then resume without loss
        start_burst(M_QPSK);
        dn_if.ack = 1'b0;
        do_write(6'b000000);
        do_write(6'b000001);
        up_if.dat = 6'b000010;
        repeat (4) begin
            @(negedge clk);
            check("t3_credit_hold", up_if.ack, 1'b0);
            check("t3_stb_held", dn_if.stb, 1'b1);
        end
        @(posedge clk);
        #1;
        dn_if.ack = 1'b1;
        for (int i = 2; i < 8; i++) begin
            do_write(6'(i % 4));
        end
        end_burst();

        // Mode change mid-burst is ignored; next burst picks it up
        start_burst(M_QPSK);
        do_write(6'b000011);
        mode = M_QAM64;
        do_write(6'b110110);
        do_write(6'b101001);
        end_burst();
        start_burst(M_QAM64);
        do_write(6'b110110);
        end_burst();

        // Drain with back-pressure; re-asserted CYC_I held off during drain
        start_burst(M_QPSK);
        dn_if.ack = 1'b0;
        do_write(6'b000001);
        do_write(6'b000010);
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
        up_if.cyc = 1'b0;
        @(posedge clk);
        #1;
        up_if.cyc = 1'b1;
        up_if.stb = 1'b1;
        up_if.we  = 1'b1;
        up_if.dat = 6'b000011;
        repeat (3) begin
            @(negedge clk);
            check("t5_drain_no_ack", up_if.ack, 1'b0);
            check("t5_cyc_held", dn_if.cyc, 1'b1);
        end
        @(posedge clk);
        #1;
        up_if.cyc = 1'b0;
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
        dn_if.ack = 1'b1;
        n = 0;
        @(negedge clk);
        while (dn_if.cyc && n < 20) begin
            if (exp_q.size() != 0) begin
                check("t5_cyc_while_queued", dn_if.cyc, 1'b1);
            end
            @(negedge clk);
            n++;
        end
        check("t5_cyc_released", dn_if.cyc, 1'b0);
        check("t5_all_popped", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-burst
        start_burst(M_QPSK);
        dn_if.ack = 1'b0;
        do_write(6'b000000);
        do_write(6'b000011);
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("t6_stb_async", dn_if.stb, 1'b0);
        check("t6_cyc_async", dn_if.cyc, 1'b0);
        check("t6_cnt_async", sym_cnt, 2'd0);
        check("t6_dat_async", dn_if.dat, 32'h0);
        exp_q.delete();
        up_if.cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_flushed", dn_if.stb, 1'b0);

        // BPSK after reset
        dn_if.ack = 1'b1;
        start_burst(M_BPSK);
        do_write(6'b000001);
        do_write(6'b111110);
        end_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
